// File: rtl/vmask_pkg.sv
// vmask_pkg: shared encodings for the mask-reduction block.
// Optional feature macro: VMASK_FIRST_EN (find-first mode in vmask_reduce).
package vmask_pkg;

  // in_op encodings
  localparam logic VMASK_OP_POPC  = 1'b0;
  localparam logic VMASK_OP_FIRST = 1'b1;

  // in_sew codes: element width of the mask layout
  localparam logic [1:0] SEW_8  = 2'd0;
  localparam logic [1:0] SEW_16 = 2'd1;
  localparam logic [1:0] SEW_32 = 2'd2;
  localparam logic [1:0] SEW_64 = 2'd3;

  // Find-first "nothing set" result. Declared signed so a size cast to any
  // result width sign-extends into all-ones.
  localparam logic signed [63:0] FIRST_NONE = -64'sd1;

  // Number of elements carried by one beat of mw mask bits at element code sew.
  function automatic int elems_per_beat(input int mw, input int sew);
    return mw >> sew;
  endfunction

endpackage

// File: rtl/vmask_beat_reduce.sv
// vmask_beat_reduce: per-beat element selection, popcount and (with
// VMASK_FIRST_EN) lowest-set-element index, registered once.
module vmask_beat_reduce
  import vmask_pkg::*;
#(
  parameter  int MW        = 8,
  parameter  int SEW_WIDTH = 2,
  localparam int CNT_W     = $clog2(MW + 1),
  localparam int IDX_W     = (MW > 1) ? $clog2(MW) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vld_i,
  input  logic [MW-1:0]        m0_i,
  input  logic [SEW_WIDTH-1:0] sew_i,
  output logic                 vld_o,
  output logic [CNT_W-1:0]     cnt_o
`ifdef VMASK_FIRST_EN
  ,
  output logic                 hit_o,
  output logic [IDX_W-1:0]     idx_o,
  output logic [CNT_W-1:0]     nelem_o
`endif
);

  logic [MW-1:0]    sel_c;
  logic [CNT_W-1:0] cnt_c;
  logic [IDX_W-1:0] pos;
  int               ne;

  // Gather element i from bit (i << sew); bits between elements are dropped.
  always_comb begin
    sel_c = '0;
    cnt_c = '0;
    pos   = '0;
    ne    = elems_per_beat(MW, int'(sew_i));
    for (int i = 0; i < MW; i++) begin
      if (i < ne) begin
        pos      = IDX_W'(i << sew_i);
        sel_c[i] = m0_i[pos];
      end
    end
    for (int i = 0; i < MW; i++) begin
      cnt_c = cnt_c + CNT_W'(sel_c[i]);
    end
  end

`ifdef VMASK_FIRST_EN
  logic             hit_c;
  logic [IDX_W-1:0] idx_c;

  // Priority encoder: scanning downward leaves the lowest set element.
  always_comb begin
    hit_c = |sel_c;
    idx_c = '0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (sel_c[i]) idx_c = IDX_W'(i);
    end
  end
`endif

  // ---- stage p0 boundary: beat summary register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_o   <= 1'b0;
      cnt_o   <= '0;
`ifdef VMASK_FIRST_EN
      hit_o   <= 1'b0;
      idx_o   <= '0;
      nelem_o <= '0;
`endif
    end else begin
      vld_o   <= vld_i;
      cnt_o   <= vld_i ? cnt_c : '0;
`ifdef VMASK_FIRST_EN
      hit_o   <= vld_i & hit_c;
      idx_o   <= vld_i ? idx_c : '0;
      nelem_o <= vld_i ? CNT_W'(ne) : '0;
`endif
    end
  end

endmodule

// File: rtl/vmask_reduce.sv
// vmask_reduce: multi-beat mask reduction (vcpop.m, and vfirst.m when
// VMASK_FIRST_EN is defined). Fixed 3-cycle latency from end beat to result.
module vmask_reduce
  import vmask_pkg::*;
#(
  parameter int REQ_DATA_WIDTH  = 64,
  parameter int RESP_DATA_WIDTH = 64,
  parameter int REQ_ADDR_WIDTH  = 32,
  parameter int SEW_WIDTH       = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [REQ_DATA_WIDTH/8-1:0] in_m0,
  input  logic [SEW_WIDTH-1:0]       in_sew,
  input  logic                       in_op,
  input  logic                       in_start,
  input  logic                       in_end,
  input  logic [REQ_ADDR_WIDTH-1:0]  in_addr,
  output logic                       out_valid,
  output logic [RESP_DATA_WIDTH-1:0] out_vec,
  output logic [REQ_ADDR_WIDTH-1:0]  out_addr
);

  localparam int MW    = REQ_DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(MW + 1);

  // Operation framing: beats count only once an operation has started.
  logic                 act_q, act_d;
  logic [SEW_WIDTH-1:0] sew_q, sew_d, sew_eff;
  logic                 accept;

  // Stage p0 sideband and beat summary
  logic                      vld_p0;
  logic [CNT_W-1:0]          cnt_p0;
  logic                      start_p0, end_p0;
  logic [REQ_ADDR_WIDTH-1:0] addr_p0;

  // Stage p1 accumulator and result
  logic [RESP_DATA_WIDTH-1:0] acc_q, acc_d, acc_base;
  logic [RESP_DATA_WIDTH-1:0] res_c, res_p1;
  logic                       emit, vld_p1;
  logic [REQ_ADDR_WIDTH-1:0]  addr_p1;

`ifdef VMASK_FIRST_EN
  localparam int IDX_W = (MW > 1) ? $clog2(MW) : 1;
  logic                       op_q, op_d, op_eff, op_p0;
  logic                       hit_p0;
  logic [IDX_W-1:0]           idx_p0;
  logic [CNT_W-1:0]           nelem_p0;
  logic [RESP_DATA_WIDTH-1:0] off_q, off_d, off_base;
  logic [RESP_DATA_WIDTH-1:0] fidx_q, fidx_d, fidx_base;
  logic                       found_q, found_d, found_base;
`else
  logic unused_op;
  assign unused_op = in_op;
`endif

  // Accept a beat only inside an operation; latch sew/op on the start beat.
  always_comb begin
    accept  = in_valid & (in_start | act_q);
    sew_eff = in_start ? in_sew : sew_q;
    act_d   = act_q;
    sew_d   = sew_q;
    if (accept) begin
      act_d = ~in_end;
      if (in_start) sew_d = in_sew;
    end
  end

`ifdef VMASK_FIRST_EN
  // Mode follows the same start-beat latch as the element width.
  always_comb begin
    op_eff = in_start ? in_op : op_q;
    op_d   = (accept & in_start) ? in_op : op_q;
  end
`endif

  // Operation framing state; reset drops any open operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_q <= 1'b0;
      sew_q <= '0;
`ifdef VMASK_FIRST_EN
      op_q  <= VMASK_OP_POPC;
`endif
    end else begin
      act_q <= act_d;
      sew_q <= sew_d;
`ifdef VMASK_FIRST_EN
      op_q  <= op_d;
`endif
    end
  end

  vmask_beat_reduce #(
    .MW        (MW),
    .SEW_WIDTH (SEW_WIDTH)
  ) u_beat (
    .clk     (clk),
    .rst     (rst),
    .vld_i   (accept),
    .m0_i    (in_m0),
    .sew_i   (sew_eff),
    .vld_o   (vld_p0),
    .cnt_o   (cnt_p0)
`ifdef VMASK_FIRST_EN
    ,
    .hit_o   (hit_p0),
    .idx_o   (idx_p0),
    .nelem_o (nelem_p0)
`endif
  );

  // ---- stage p0 boundary: framing bits travelling beside the beat summary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      start_p0 <= 1'b0;
      end_p0   <= 1'b0;
      addr_p0  <= '0;
`ifdef VMASK_FIRST_EN
      op_p0    <= VMASK_OP_POPC;
`endif
    end else begin
      start_p0 <= accept & in_start;
      end_p0   <= accept & in_end;
      addr_p0  <= accept ? in_addr : '0;
`ifdef VMASK_FIRST_EN
      op_p0    <= op_eff;
`endif
    end
  end

  // Fold the beat into the running state; a start beat begins from zero.
  always_comb begin
    acc_base = start_p0 ? '0 : acc_q;
    acc_d    = acc_q;
    if (vld_p0) acc_d = acc_base + RESP_DATA_WIDTH'(cnt_p0);
    res_c = acc_d;
`ifdef VMASK_FIRST_EN
    off_base   = start_p0 ? '0 : off_q;
    fidx_base  = start_p0 ? '0 : fidx_q;
    found_base = start_p0 ? 1'b0 : found_q;
    off_d      = off_q;
    fidx_d     = fidx_q;
    found_d    = found_q;
    if (vld_p0) begin
      off_d   = off_base + RESP_DATA_WIDTH'(nelem_p0);
      found_d = found_base | hit_p0;
      fidx_d  = fidx_base;
      if (!found_base && hit_p0) fidx_d = off_base + RESP_DATA_WIDTH'(idx_p0);
    end
    if (op_p0 == VMASK_OP_FIRST) res_c = found_d ? fidx_d : RESP_DATA_WIDTH'(FIRST_NONE);
`endif
    emit = vld_p0 & end_p0;
  end

  // ---- stage p1 boundary: accumulator and finished result ----
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      vld_p1  <= 1'b0;
      res_p1  <= '0;
      addr_p1 <= '0;
`ifdef VMASK_FIRST_EN
      off_q   <= '0;
      fidx_q  <= '0;
      found_q <= 1'b0;
`endif
    end else begin
      acc_q   <= acc_d;
      vld_p1  <= emit;
      res_p1  <= emit ? res_c : '0;
      addr_p1 <= emit ? addr_p0 : '0;
`ifdef VMASK_FIRST_EN
      off_q   <= off_d;
      fidx_q  <= fidx_d;
      found_q <= found_d;
`endif
    end
  end

  // ---- stage p2 boundary: output register, zero when not valid ----
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_vec   <= '0;
      out_addr  <= '0;
    end else begin
      out_valid <= vld_p1;
      out_vec   <= res_p1;
      out_addr  <= addr_p1;
    end
  end

endmodule

// File: tb/tb_vmask_reduce.sv
// tb_vmask_reduce: directed bench for vmask_reduce with a flat element-list
// reference model. Follows VMASK_FIRST_EN the same way the design does.
module tb_vmask_reduce;

`ifdef VMASK_FIRST_EN
  localparam bit FIRST = 1'b1;
`else
  localparam bit FIRST = 1'b0;
`endif
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_op, in_start, in_end;
  logic [7:0]  in_m0;
  logic [1:0]  in_sew;
  logic [31:0] in_addr;
  logic        out_valid;
  logic [63:0] out_vec;
  logic [31:0] out_addr;

  vmask_reduce #(
    .REQ_DATA_WIDTH  (64),
    .RESP_DATA_WIDTH (64),
    .REQ_ADDR_WIDTH  (32),
    .SEW_WIDTH       (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_m0     (in_m0),
    .in_sew    (in_sew),
    .in_op     (in_op),
    .in_start  (in_start),
    .in_end    (in_end),
    .in_addr   (in_addr),
    .out_valid (out_valid),
    .out_vec   (out_vec),
    .out_addr  (out_addr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n     = 0;   // index of the most recent rising edge

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // Reference model: an operation is the flat list of selected element bits.
  bit          m_act = 1'b0;
  logic [1:0]  m_sew;
  logic        m_op;
  bit          m_el[$];
  logic [63:0] exp_vec[int];
  logic [31:0] exp_addr[int];

  always @(posedge clk) begin
    logic [63:0] res;
    n = n + 1;
    if (rst) begin
      m_act = 1'b0;
      m_el.delete();
      exp_vec.delete();
      exp_addr.delete();
    end else if (in_valid && (in_start || m_act)) begin
      if (in_start) begin
        m_act = 1'b1;
        m_sew = in_sew;
        m_op  = in_op;
        m_el.delete();
      end
      for (int i = 0; i < (8 >> m_sew); i++) m_el.push_back(in_m0[i << m_sew]);
      if (in_end) begin
        res = 0;
        foreach (m_el[i]) res = res + 64'(m_el[i]);
        if (FIRST && m_op) begin
          res = ONES;
          for (int i = m_el.size() - 1; i >= 0; i--) if (m_el[i]) res = 64'(i);
        end
        // A beat sampled at edge k is visible after edge k+2 (cycle T+3).
        exp_vec[n + 2]  = res;
        exp_addr[n + 2] = in_addr;
        m_act = 1'b0;
      end
    end
  end

  // Every-cycle compare against the model; also log pulses for literal checks.
  logic [63:0] got_vec[$];
  int          got_cyc[$];

  always @(negedge clk) begin
    if (n >= 1) begin
      if (exp_vec.exists(n)) begin
        check($sformatf("valid@%0d", n), 64'(out_valid), 64'd1);
        check($sformatf("vec@%0d", n), out_vec, exp_vec[n]);
        check($sformatf("addr@%0d", n), 64'(out_addr), 64'(exp_addr[n]));
        exp_vec.delete(n);
        exp_addr.delete(n);
      end else begin
        check($sformatf("idle_valid@%0d", n), 64'(out_valid), 64'd0);
        check($sformatf("idle_vec@%0d", n), out_vec, 64'd0);
        check($sformatf("idle_addr@%0d", n), 64'(out_addr), 64'd0);
      end
      if (out_valid === 1'b1) begin
        got_vec.push_back(out_vec);
        got_cyc.push_back(n);
      end
    end
  end

  task automatic idle_in();
    in_valid = 1'b0; in_m0 = '0; in_sew = '0; in_op = 1'b0;
    in_start = 1'b0; in_end = 1'b0; in_addr = '0;
  endtask

  task automatic beat(input logic [7:0] m, input logic [1:0] sew, input logic op,
                      input logic s, input logic e, input logic [31:0] a);
    in_valid = 1'b1; in_m0 = m; in_sew = sew; in_op = op;
    in_start = s; in_end = e; in_addr = a;
    @(posedge clk); #1;
    idle_in();
  endtask

  // Invalid cycle with noisy inputs that must be ignored.
  task automatic bubble();
    in_valid = 1'b0; in_m0 = 8'($urandom); in_sew = 2'($urandom);
    in_op = 1'b1; in_start = 1'b1; in_end = 1'b1; in_addr = $urandom;
    @(posedge clk); #1;
    idle_in();
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin @(posedge clk); #1; end
  endtask

  task automatic lit(input string name, input int k, input logic [63:0] v, input int cyc);
    if (got_vec.size() > k) begin
      check({name, "_vec"}, got_vec[k], v);
      if (cyc >= 0) check({name, "_cyc"}, 64'(got_cyc[k]), 64'(cyc));
    end else begin
      check({name, "_missing"}, 64'(got_vec.size()), 64'(k + 1));
    end
  endtask

  initial begin
    int k;
    int t;
    rst = 1'b1;
    idle_in();
    idle(3);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_vec", out_vec, 64'd0);
    check("rst_addr", 64'(out_addr), 64'd0);
    rst = 1'b0;
    idle(1);

    // End beat with no preceding start after reset: ignored.
    k = got_vec.size();
    beat(8'hFF, 2'd0, 1'b0, 1'b0, 1'b1, 32'h10);
    idle(5);
    check("nostart_cnt", 64'(got_vec.size()), 64'(k));

    // Single beat popcount, latency check.
    k = got_vec.size();
    beat(8'hFF, 2'd0, 1'b0, 1'b1, 1'b1, 32'h100);
    t = n;
    idle(5);
    lit("popc_ff", k, 64'd8, t + 2);

    // sew=2 with bubble; ignored bits set; mid-op sew/op changes ignored.
    k = got_vec.size();
    beat(8'h11, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0);
    bubble();
    beat(8'h01, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    beat(8'h10, 2'd1, 1'b1, 1'b0, 1'b1, 32'h200);
    beat(8'hFF, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0);
    bubble();
    beat(8'hEF, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    beat(8'hFE, 2'd3, 1'b1, 1'b0, 1'b1, 32'h204);
    idle(5);
    lit("sew2", k, 64'd4, -1);
    lit("sew2_ignored", k + 1, 64'd4, -1);

    // Find-first across beats, then an all-zero operation.
    k = got_vec.size();
    beat(8'h00, 2'd0, 1'b1, 1'b1, 1'b0, 32'h0);
    beat(8'h00, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    beat(8'h20, 2'd0, 1'b1, 1'b0, 1'b1, 32'h300);
    beat(8'h00, 2'd0, 1'b1, 1'b1, 1'b0, 32'h0);
    beat(8'h00, 2'd0, 1'b1, 1'b0, 1'b1, 32'h304);
    idle(5);
    lit("first21", k, FIRST ? 64'd21 : 64'd1, -1);
    lit("first_none", k + 1, FIRST ? ONES : 64'd0, -1);

    // sew=1 find-first; second beat's sew=0 must be ignored (elem 4+1).
    k = got_vec.size();
    beat(8'h00, 2'd1, 1'b1, 1'b1, 1'b0, 32'h0);
    beat(8'h0C, 2'd0, 1'b1, 1'b0, 1'b1, 32'h380);
    idle(5);
    lit("sew1_first", k, FIRST ? 64'd5 : 64'd1, -1);

    // Back-to-back operations with no gap.
    k = got_vec.size();
    beat(8'h0F, 2'd0, 1'b0, 1'b1, 1'b1, 32'h400);
    t = n;
    beat(8'h03, 2'd0, 1'b0, 1'b1, 1'b1, 32'h404);
    idle(5);
    lit("b2b_a", k, 64'd4, t + 2);
    lit("b2b_b", k + 1, 64'd2, t + 3);

    // Restart without end discards the old state.
    k = got_vec.size();
    beat(8'hFF, 2'd0, 1'b0, 1'b1, 1'b0, 32'h0);
    beat(8'h01, 2'd0, 1'b0, 1'b1, 1'b1, 32'h500);
    idle(5);
    lit("restart", k, 64'd1, -1);

    // Reset mid-operation, and reset right after an end beat.
    k = got_vec.size();
    beat(8'h01, 2'd0, 1'b0, 1'b1, 1'b0, 32'h0);
    beat(8'h01, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1; idle(1); rst = 1'b0;
    beat(8'h01, 2'd0, 1'b0, 1'b0, 1'b1, 32'h600);
    beat(8'h07, 2'd0, 1'b0, 1'b1, 1'b1, 32'h604);
    rst = 1'b1; idle(1); rst = 1'b0;
    idle(5);
    check("rst_drop_cnt", 64'(got_vec.size()), 64'(k));
    beat(8'h01, 2'd0, 1'b0, 1'b1, 1'b1, 32'h608);
    idle(5);
    lit("after_rst", k, 64'd1, -1);

    // in_op=1: find-first gives 4, popcount-only build gives 2.
    k = got_vec.size();
    beat(8'h30, 2'd0, 1'b1, 1'b1, 1'b1, 32'h700);
    idle(5);
    lit("op1_30", k, FIRST ? 64'd4 : 64'd2, -1);

    // sew=3: one element per beat.
    k = got_vec.size();
    beat(8'hFE, 2'd3, 1'b1, 1'b1, 1'b0, 32'h0);
    beat(8'h00, 2'd3, 1'b1, 1'b0, 1'b0, 32'h0);
    beat(8'h01, 2'd3, 1'b1, 1'b0, 1'b1, 32'h800);
    idle(5);
    lit("sew3", k, FIRST ? 64'd2 : 64'd1, -1);

    check("model_drained", 64'(exp_vec.num()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
